// File: rtl/otter_mmio_pkg.sv
// Shared address map defaults and decode helper for the OTTER MMIO hub.
package otter_mmio_pkg;

  localparam logic [31:0] OUT_BASE_DEF = 32'h1100_0020;
  localparam logic [31:0] IN_BASE_DEF  = 32'h1100_0000;
  localparam logic [31:0] STRIDE_DEF   = 32'h0000_0020;
  localparam logic [31:0] IRQ_BASE_DEF = 32'h1100_0200;

  // Address of port idx in a bank starting at base with the given step.
  function automatic logic [31:0] port_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input int unsigned idx);
    logic [31:0] idx_w;
    idx_w = idx;
    return base + stride * idx_w;
  endfunction

endpackage

// File: rtl/mmio_irq_capture.sv
// Interrupt capture: 2-flop synchroniser, rising-edge detect, pending/mask
// registers and the registered interrupt request.
module mmio_irq_capture
  import otter_mmio_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] src,
  input  logic [N_IRQ-1:0] clr,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             intr
);

  logic [N_IRQ-1:0] sync1;
  logic [N_IRQ-1:0] sync2;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] rise;

  // Bring the asynchronous sources into the clock domain and keep one more
  // stage of history so a level held high only registers once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Pending bits: write-1-to-clear, but a new edge in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | rise;
  end

  // Mask register loaded by software.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask <= '0;
    else if (mask_wr) mask <= mask_data;
  end

  // Interrupt request lags the pending/mask state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) intr <= 1'b0;
    else     intr <= |(pending & mask);
  end

endmodule

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub: output registers with write strobes, input ports,
// and an interrupt status/mask pair, all on the OTTER MCU I/O bus.
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter int          N_OUT    = 4,
  parameter int          N_IN     = 4,
  parameter int          N_IRQ    = 8,
  parameter logic [31:0] OUT_BASE = OUT_BASE_DEF,
  parameter logic [31:0] IN_BASE  = IN_BASE_DEF,
  parameter logic [31:0] STRIDE   = STRIDE_DEF,
  parameter logic [31:0] IRQ_BASE = IRQ_BASE_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       IOBUS_ADDR,
  input  logic [31:0]       IOBUS_OUT,
  input  logic              IOBUS_WR,
  output logic [31:0]       IOBUS_IN,
  input  logic [N_IN*32-1:0]  IN_DATA,
  output logic [N_OUT*32-1:0] OUT_DATA,
  output logic [N_OUT-1:0]  OUT_STB,
  input  logic [N_IRQ-1:0]  IRQ_SRC,
  output logic              INTR
);

  logic [N_OUT-1:0] out_hit;
  logic [N_IN-1:0]  in_hit;
  logic             stat_hit;
  logic             mask_hit;
  logic [N_IRQ-1:0] irq_clr;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [31:0]      rd_data;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic [31:0] data;
    assign out_hit[k] = (IOBUS_ADDR == port_addr(OUT_BASE, STRIDE, k));

    // Output register k captures the bus data on a matching write.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                      data <= '0;
      else if (IOBUS_WR && out_hit[k]) data <= IOBUS_OUT;
    end

    assign OUT_DATA[32*k +: 32] = data;
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    assign in_hit[k] = (IOBUS_ADDR == port_addr(IN_BASE, STRIDE, k));
  end

  assign stat_hit = (IOBUS_ADDR == IRQ_BASE);
  assign mask_hit = (IOBUS_ADDR == IRQ_BASE + STRIDE);
  assign irq_clr  = (IOBUS_WR && stat_hit) ? IOBUS_OUT[N_IRQ-1:0] : '0;

  // One-cycle strobe in the cycle after each accepted output write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) OUT_STB <= '0;
    else       OUT_STB <= IOBUS_WR ? out_hit : '0;
  end

  mmio_irq_capture #(
    .N_IRQ(N_IRQ)
  ) u_irq (
    .clk      (CLK),
    .rst      (RESET),
    .src      (IRQ_SRC),
    .clr      (irq_clr),
    .mask_wr  (IOBUS_WR && mask_hit),
    .mask_data(IOBUS_OUT[N_IRQ-1:0]),
    .pending  (pending),
    .mask     (mask),
    .intr     (INTR)
  );

  // Read mux; later assignments win, so output read-back beats an input
  // port at the same address, which in turn beats the IRQ registers.
  always_comb begin
    rd_data = '0;
    if (stat_hit) rd_data = 32'(pending);
    if (mask_hit) rd_data = 32'(mask);
    for (int k = 0; k < N_IN; k++)
      if (in_hit[k]) rd_data = IN_DATA[32*k +: 32];
    for (int k = 0; k < N_OUT; k++)
      if (out_hit[k]) rd_data = OUT_DATA[32*k +: 32];
  end

  assign IOBUS_IN = rd_data;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Directed self-checking bench for otter_mmio_hub with default parameters.
module tb_otter_mmio_hub;

  localparam logic [31:0] IRQ_STAT = 32'h1100_0200;
  localparam logic [31:0] IRQ_MASK = 32'h1100_0220;

  logic         CLK;
  logic         RESET;
  logic [31:0]  IOBUS_ADDR;
  logic [31:0]  IOBUS_OUT;
  logic         IOBUS_WR;
  logic [31:0]  IOBUS_IN;
  logic [127:0] IN_DATA;
  logic [127:0] OUT_DATA;
  logic [3:0]   OUT_STB;
  logic [7:0]   IRQ_SRC;
  logic         INTR;

  int checks;
  int failures;

  otter_mmio_hub dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_STB   (OUT_STB),
    .IRQ_SRC   (IRQ_SRC),
    .INTR      (INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    IOBUS_WR   = wr;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus(1'b0, IRQ_MASK, 32'h0);
    IN_DATA = '0;
    IRQ_SRC = '0;
    #1;
    checks++; if (OUT_DATA !== 128'h0) begin failures++; $display("[TB] FAIL reset_out_data got %h want 0", OUT_DATA); end
    checks++; if (OUT_STB !== 4'b0) begin failures++; $display("[TB] FAIL reset_out_stb got %b want 0000", OUT_STB); end
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL reset_intr got %b want 0", INTR); end
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL reset_mask_read got %h want 0", IOBUS_IN); end
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic test_write_strobe();
    bus(1'b1, 32'h1100_0020, 32'h0000_00A5);
    tick();
    bus(1'b0, 32'h1100_0020, 32'h0);
    checks++; if (OUT_DATA[7:0] !== 8'hA5) begin failures++; $display("[TB] FAIL wr0_data got %h want a5", OUT_DATA[7:0]); end
    checks++; if (OUT_STB !== 4'b0001) begin failures++; $display("[TB] FAIL wr0_stb got %b want 0001", OUT_STB); end
    tick();
    checks++; if (OUT_STB !== 4'b0000) begin failures++; $display("[TB] FAIL wr0_stb_drop got %b want 0000", OUT_STB); end
    checks++; if (OUT_DATA[31:0] !== 32'hA5) begin failures++; $display("[TB] FAIL wr0_hold got %h want a5", OUT_DATA[31:0]); end
  endtask

  task automatic test_back_to_back();
    bus(1'b1, 32'h1100_0040, 32'hDEAD_BEEF);
    tick();
    checks++; if (OUT_STB !== 4'b0010) begin failures++; $display("[TB] FAIL b2b_stb1 got %b want 0010", OUT_STB); end
    bus(1'b1, 32'h1100_0060, 32'hCAFE_0001);
    tick();
    checks++; if (OUT_STB !== 4'b0100) begin failures++; $display("[TB] FAIL b2b_stb2 got %b want 0100", OUT_STB); end
    bus(1'b0, 32'h1100_0040, 32'h0);
    tick();
    checks++; if (OUT_STB !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_stb_end got %b want 0000", OUT_STB); end
    checks++; if (IOBUS_IN !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL b2b_readback got %h want deadbeef", IOBUS_IN); end
    checks++; if (OUT_DATA[95:64] !== 32'hCAFE_0001) begin failures++; $display("[TB] FAIL b2b_reg2 got %h want cafe0001", OUT_DATA[95:64]); end
  endtask

  task automatic test_read_priority();
    IN_DATA[31:0]  = 32'h0000_55AA;
    IN_DATA[63:32] = 32'h0000_1234;
    bus(1'b0, 32'h1100_0000, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h55AA) begin failures++; $display("[TB] FAIL rd_in0 got %h want 55aa", IOBUS_IN); end
    bus(1'b0, 32'h1100_0020, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'hA5) begin failures++; $display("[TB] FAIL rd_overlap got %h want a5", IOBUS_IN); end
    bus(1'b0, 32'h1100_0300, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL rd_unmapped got %h want 0", IOBUS_IN); end
    bus(1'b0, 32'h1100_0021, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL rd_near_miss got %h want 0", IOBUS_IN); end
  endtask

  task automatic test_ignored_writes();
    bus(1'b1, 32'h1100_0000, 32'hFFFF_FFFF);
    tick();
    checks++; if (OUT_STB !== 4'b0000) begin failures++; $display("[TB] FAIL ign_in_stb got %b want 0000", OUT_STB); end
    bus(1'b1, 32'h1100_0300, 32'hFFFF_FFFF);
    tick();
    checks++; if (OUT_STB !== 4'b0000) begin failures++; $display("[TB] FAIL ign_unm_stb got %b want 0000", OUT_STB); end
    checks++; if (OUT_DATA !== {32'h0, 32'hCAFE_0001, 32'hDEAD_BEEF, 32'hA5}) begin failures++; $display("[TB] FAIL ign_regs got %h", OUT_DATA); end
    bus(1'b0, IRQ_MASK, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL ign_mask got %h want 0", IOBUS_IN); end
  endtask

  task automatic test_irq();
    bus(1'b1, IRQ_MASK, 32'h04);
    tick();
    bus(1'b0, IRQ_MASK, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h04) begin failures++; $display("[TB] FAIL irq_mask_rd got %h want 04", IOBUS_IN); end
    bus(1'b0, IRQ_STAT, 32'h0);
    IRQ_SRC[2] = 1'b1;
    tick(); tick(); tick();
    checks++; if (IOBUS_IN !== 32'h04) begin failures++; $display("[TB] FAIL irq_pend_e3 got %h want 04", IOBUS_IN); end
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL irq_intr_e3 got %b want 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL irq_intr_e4 got %b want 1", INTR); end
    IRQ_SRC[2] = 1'b0;
    bus(1'b1, IRQ_STAT, 32'h04);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL irq_w1c got %h want 0", IOBUS_IN); end
    tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL irq_intr_clr got %b want 0", INTR); end
    // Held-high source: clear once, must not re-arm until it toggles.
    IRQ_SRC[3] = 1'b1;
    tick(); tick(); tick();
    bus(1'b1, IRQ_STAT, 32'h08);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0);
    tick(); tick(); tick();
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL irq_held got %h want 0", IOBUS_IN); end
    IRQ_SRC[3] = 1'b0;
    tick(); tick(); tick();
    IRQ_SRC[3] = 1'b1;
    tick(); tick(); tick();
    checks++; if (IOBUS_IN !== 32'h08) begin failures++; $display("[TB] FAIL irq_rearm got %h want 08", IOBUS_IN); end
    IRQ_SRC[3] = 1'b0;
    bus(1'b1, IRQ_STAT, 32'hFF);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0);
  endtask

  task automatic test_coincident_clear();
    bus(1'b1, IRQ_MASK, 32'h0);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0);
    IRQ_SRC[0] = 1'b1;
    tick(); tick();
    bus(1'b1, IRQ_STAT, 32'h01);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0); #1;
    checks++; if (IOBUS_IN !== 32'h01) begin failures++; $display("[TB] FAIL coin_pend got %h want 01", IOBUS_IN); end
    tick();
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL coin_intr got %b want 0", INTR); end
  endtask

  task automatic test_reset_midwrite();
    bus(1'b1, IRQ_MASK, 32'hFF);
    tick();
    bus(1'b0, IRQ_STAT, 32'h0);
    tick(); tick();
    checks++; if (INTR !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_intr got %b want 1", INTR); end
    bus(1'b1, 32'h1100_0020, 32'h77);
    #2;
    RESET = 1'b1;
    bus(1'b1, IRQ_STAT, 32'h0);
    #1;
    checks++; if (OUT_DATA !== 128'h0) begin failures++; $display("[TB] FAIL rst_async_data got %h want 0", OUT_DATA); end
    checks++; if (INTR !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_intr got %b want 0", INTR); end
    checks++; if (IOBUS_IN !== 32'h0) begin failures++; $display("[TB] FAIL rst_async_pend got %h want 0", IOBUS_IN); end
    bus(1'b1, 32'h1100_0020, 32'h77);
    tick();
    checks++; if (OUT_STB !== 4'b0000) begin failures++; $display("[TB] FAIL rst_stb got %b want 0000", OUT_STB); end
    checks++; if (OUT_DATA !== 128'h0) begin failures++; $display("[TB] FAIL rst_hold_data got %h want 0", OUT_DATA); end
    IRQ_SRC = '0;
    bus(1'b1, 32'h1100_0080, 32'h99);
    RESET = 1'b0;
    tick();
    bus(1'b0, 32'h1100_0080, 32'h0);
    checks++; if (OUT_STB !== 4'b1000) begin failures++; $display("[TB] FAIL post_rst_stb got %b want 1000", OUT_STB); end
    checks++; if (OUT_DATA[127:96] !== 32'h99) begin failures++; $display("[TB] FAIL post_rst_data got %h want 99", OUT_DATA[127:96]); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_strobe();
    test_back_to_back();
    test_read_priority();
    test_ignored_writes();
    test_irq();
    test_coincident_clear();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
